// File: rtl/mult_div_unit_pkg.sv
// Shared CPU parameter definitions: ALU and mult/div op codes, mult/div latency defaults,
// and the behavioural divide helper.
package mult_div_unit_pkg;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluNor  = 4'd5,
        AluSlt  = 4'd6,
        AluSltu = 4'd7,
        AluSll  = 4'd8,
        AluSrl  = 4'd9,
        AluSra  = 4'd10,
        AluLui  = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        MdNone  = 3'd0,
        MdMult  = 3'd1,
        MdMultu = 3'd2,
        MdDiv   = 3'd3,
        MdDivu  = 3'd4,
        MdMthi  = 3'd5,
        MdMtlo  = 3'd6
    } md_op_e;

    // Returns {remainder, quotient}. Works on magnitudes so INT_MIN / -1 wraps to INT_MIN
    // instead of overflowing; the remainder takes the dividend's sign.
    function automatic logic [63:0] div_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic is_signed);
        logic        a_neg;
        logic        b_neg;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] q;
        logic [31:0] r;
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];
        a_mag = a_neg ? (~a + 32'd1) : a;
        b_mag = b_neg ? (~b + 32'd1) : b;
        if (b_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        q = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        r = a_neg ? (~r_mag + 32'd1) : r_mag;
        return {r, q};
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: result computed behaviourally at Start, then a counter
// holds Busy for the configured latency before committing to HI/LO.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_div0;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_tmp_hi;
    logic [31:0]        r_tmp_lo;

    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic [63:0]        w_div;
    md_op_e             w_op;

    assign w_op     = md_op_e'(MDOp);
    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};
    assign w_div    = div_calc(A, B, w_op == MdDiv);

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_tmp_hi <= '0;
            r_tmp_lo <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Start) begin
                        case (w_op)
                            MdMult, MdMultu: begin
                                r_tmp_hi <= (w_op == MdMult) ? w_prod_s[63:32] : w_prod_u[63:32];
                                r_tmp_lo <= (w_op == MdMult) ? w_prod_s[31:0]  : w_prod_u[31:0];
                                r_div0   <= 1'b0;
                                r_cnt    <= CNT_W'(MULT_CYCLES);
                                r_busy   <= 1'b1;
                                r_state  <= StRun;
                            end
                            MdDiv, MdDivu: begin
                                r_tmp_hi <= w_div[63:32];
                                r_tmp_lo <= w_div[31:0];
                                r_div0   <= (B == 32'd0);
                                r_cnt    <= CNT_W'(DIV_CYCLES);
                                r_busy   <= 1'b1;
                                r_state  <= StRun;
                            end
                            MdMthi:  r_hi <= A;
                            MdMtlo:  r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    // Start/MDOp are deliberately ignored for the whole run.
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        if (!r_div0) begin
                            r_hi <= r_tmp_hi;
                            r_lo <= r_tmp_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit plus hand sequences for the
// start-while-busy, no-op and reset corner cases.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int failures;

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .Start  (Start),
        .MDOp   (MDOp),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch one op and check Busy each cycle, then HI/LO in the first non-busy cycle.
    task automatic run_op(input vec_t v);
        @(negedge clk);
        Start = 1'b1;
        MDOp  = v.op;
        A     = v.a;
        B     = v.b;
        check({v.name, " busy@start"}, {31'd0, Busy}, 32'd0);
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDOp  = MdNone;
        A     = 32'hDEAD_BEEF;
        B     = 32'h0BAD_F00D;
        for (int i = 0; i < v.cycles; i++) begin
            check($sformatf("%s busy@%0d", v.name, i + 1), {31'd0, Busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        check({v.name, " busy@end"}, {31'd0, Busy}, 32'd0);
        check({v.name, " HI"}, HI, v.hi);
        check({v.name, " LO"}, LO, v.lo);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        Start    = 1'b0;
        MDOp     = MdNone;
        A        = '0;
        B        = '0;

        vecs.push_back('{"mult_neg",   MdMult,  32'hFFFF_FFFE, 32'd3,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFA});
        vecs.push_back('{"multu_big",  MdMultu, 32'hFFFF_FFFF, 32'd2,          5,  32'h0000_0001, 32'hFFFF_FFFE});
        vecs.push_back('{"multu_max",  MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5,  32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{"mult_min",   MdMult,  32'h8000_0000, 32'h8000_0000,  5,  32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{"div_neg",    MdDiv,   32'hFFFF_FFF9, 32'd2,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{"div_negb",   MdDiv,   32'd7,         32'hFFFF_FFFE,  10, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{"divu",       MdDivu,  32'd100,       32'd7,          10, 32'h0000_0002, 32'h0000_000E});
        vecs.push_back('{"div_ovf",    MdDiv,   32'h8000_0000, 32'hFFFF_FFFF,  10, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{"mthi",       MdMthi,  32'h0000_0011, 32'd0,          0,  32'h0000_0011, 32'h8000_0000});
        vecs.push_back('{"mtlo",       MdMtlo,  32'h0000_0022, 32'd0,          0,  32'h0000_0011, 32'h0000_0022});
        vecs.push_back('{"divu_zero",  MdDivu,  32'h1234_5678, 32'd0,          10, 32'h0000_0011, 32'h0000_0022});
        vecs.push_back('{"div_zero",   MdDiv,   32'hFFFF_0000, 32'd0,          10, 32'h0000_0011, 32'h0000_0022});

        #2;
        check("reset busy", {31'd0, Busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // MDOp = none must not disturb anything.
        @(negedge clk);
        Start = 1'b1;
        MDOp  = MdNone;
        A     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        Start = 1'b0;
        check("none busy", {31'd0, Busy}, 32'd0);
        check("none HI", HI, 32'h0000_0011);
        check("none LO", LO, 32'h0000_0022);

        // mult 3x4 with an mtlo attempted in Busy cycle 2.
        @(negedge clk);
        Start = 1'b1;
        MDOp  = MdMult;
        A     = 32'd3;
        B     = 32'd4;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDOp  = MdNone;
        check("sb busy@1", {31'd0, Busy}, 32'd1);
        @(posedge clk);
        #1;
        Start = 1'b1;
        MDOp  = MdMtlo;
        A     = 32'h55;
        for (int c = 2; c <= 5; c++) begin
            check($sformatf("sb busy@%0d", c), {31'd0, Busy}, 32'd1);
            @(posedge clk);
            #1;
            Start = (c == 4);
            MDOp  = (c == 4) ? MdMthi : MdNone;
        end
        Start = 1'b0;
        MDOp  = MdNone;
        check("sb busy@6", {31'd0, Busy}, 32'd0);
        check("sb LO", LO, 32'd12);
        check("sb HI", HI, 32'd0);
        @(posedge clk);
        #1;
        check("sb LO hold", LO, 32'd12);

        // Reset during div Busy cycle 4.
        @(negedge clk);
        Start = 1'b1;
        MDOp  = MdDiv;
        A     = 32'd100;
        B     = 32'd3;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDOp  = MdNone;
        for (int c = 1; c < 4; c++) begin
            @(posedge clk);
            #1;
        end
        check("rst busy pre", {31'd0, Busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst busy", {31'd0, Busy}, 32'd0);
        check("rst HI", HI, 32'd0);
        check("rst LO", LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("rst busy after", {31'd0, Busy}, 32'd0);
        check("rst HI after", HI, 32'd0);
        check("rst LO after", LO, 32'd0);

        // Start presented in the very cycle reset is released.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        Start   = 1'b1;
        MDOp    = MdMthi;
        A       = 32'h0000_ABCD;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDOp  = MdNone;
        check("post-rst mthi", HI, 32'h0000_ABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
